// File: rtl/csr_sel_decoder.sv
// csr_sel_decoder
//   APB-style register select decoder. A transfer is a setup cycle, one wait
//   cycle and one ready cycle. The decoder produces a one-hot write strobe
//   (ready cycle only) and a one-hot read select (wait and ready cycles). It
//   returns read data from a flat bus of register contents, flags misses with
//   pslverr, and keeps a saturating count of error responses.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_en                    block enable, sampled at setup
//   i_psel, i_penable       APB phase controls
//   i_pwrite, i_paddr       direction and register address, latched at setup
//   i_rdata_bus             register k on [k*DATA_WIDTH +: DATA_WIDTH]
//   o_wr_sel, o_rd_sel      one-hot write strobe / read select
//   o_prdata                read data, valid in the ready cycle only
//   o_pready, o_pslverr     transfer complete / error response
//   o_err_cnt               saturating count of error responses
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer, waiting for a setup phase
// WAIT  | setup latched, expecting the enable phase
// RESP  | ready cycle: pready plus strobe, read data or error
module csr_sel_decoder #(
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [ADDR_WIDTH-1:0]          i_paddr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_rdata_bus,
  output logic [NUM_REGS-1:0]            o_wr_sel,
  output logic [NUM_REGS-1:0]            o_rd_sel,
  output logic [DATA_WIDTH-1:0]          o_prdata,
  output logic                           o_pready,
  output logic                           o_pslverr,
  output logic [7:0]                     o_err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // One extra bit so NUM_REGS = 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic                  hit_q;

  logic                  setup_ph;
  logic                  access_ph;
  logic                  hit_now;
  logic [NUM_REGS-1:0]   sel_now;
  logic [NUM_REGS-1:0]   sel_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign setup_ph  = i_psel & ~i_penable;
  assign access_ph = i_psel & i_penable;
  assign hit_now   = i_en & ({1'b0, i_paddr} < REG_LIMIT);

  always_comb begin
    sel_now = '0;
    sel_q   = '0;
    rdata_q = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      sel_now[k] = (i_paddr == ADDR_WIDTH'(k));
      sel_q[k]   = (addr_q == ADDR_WIDTH'(k));
      if (addr_q == ADDR_WIDTH'(k)) begin
        rdata_q = i_rdata_bus[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      hit_q     <= 1'b0;
      o_wr_sel  <= '0;
      o_rd_sel  <= '0;
      o_prdata  <= '0;
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      // Response outputs live for the ready cycle only.
      o_wr_sel  <= '0;
      o_prdata  <= '0;
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (setup_ph) begin
            state    <= S_WAIT;
            addr_q   <= i_paddr;
            write_q  <= i_pwrite;
            hit_q    <= hit_now;
            o_rd_sel <= (hit_now && !i_pwrite) ? sel_now : '0;
          end else begin
            state    <= S_IDLE;
            o_rd_sel <= '0;
          end
        end
        S_WAIT: begin
          if (access_ph) begin
            state    <= S_RESP;
            o_pready <= 1'b1;
            if (hit_q) begin
              if (write_q) o_wr_sel <= sel_q;
              else         o_prdata <= rdata_q;
            end else begin
              // Counter moves together with the pslverr it counts.
              o_pslverr <= 1'b1;
              if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
            end
          end else begin
            state    <= S_IDLE;
            o_rd_sel <= '0;
          end
        end
        default: begin
          state    <= S_IDLE;
          o_rd_sel <= '0;
        end
      endcase
    end
  end

endmodule
